dcache_refill_ctrl: RTL and testbench

- Memory-side miss handler for the 2-way dcache data array.
- On a miss it first evicts the dirty victim line:
  - pulses `write_back` to read the victim line from the data array;
  - captures `cacheline_old`;
  - writes it to memory over AXI4.
- It then fetches the missing line over AXI4, presents it on `cacheline_new`, and pulses `refresh` so the array writes it into the LRU way.
- It sits between the dcache tag/LRU logic and the system AXI interconnect.

---
 rtl/dcache_refill_ctrl_pkg.sv | 23 ++
 rtl/dcache_refill_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_dcache_refill_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_refill_ctrl_pkg.sv
// Shared constants and state encoding for the dcache refill controller.
package dcache_refill_ctrl_pkg;

    localparam int          CACHELINE_WIDTH = 64;

    localparam logic [2:0]  SIZE_8B    = 3'b011;
    localparam logic [1:0]  BURST_INCR = 2'b01;
    localparam logic [1:0]  RESP_OKAY  = 2'b00;

    // Nine states, so the encoding needs four bits.
    typedef enum logic [3:0] {
        S_IDLE,
        S_WB_RD,
        S_WB_CAP,
        S_WB_AW_W,
        S_WB_B,
        S_RD_AR,
        S_RD_R,
        S_REFILL,
        S_DONE
    } state_e;

endpackage

// File: rtl/dcache_refill_ctrl.sv
// Miss handler: evicts a dirty victim line over AXI4, then refills the missing line.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for miss_req; latches miss/victim addresses
// WB_RD     | write_back strobe reads the victim line from the data array
// WB_CAP    | victim data captured from cacheline_old
// WB_AW_W   | AW and W issued together, each retired independently
// WB_B      | waiting for the write response
// RD_AR     | read address issued
// RD_R      | waiting for the single read beat
// REFILL    | refresh strobe writes cacheline_new into the LRU way
// DONE      | miss_done pulse
import dcache_refill_ctrl_pkg::*;

module dcache_refill_ctrl #(
    parameter int         ADDR_WIDTH = 64,
    parameter int         LINE_WIDTH = CACHELINE_WIDTH,
    parameter logic [3:0] AXI_ID     = 4'd1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    miss_req,
    input  logic [ADDR_WIDTH-1:0]   miss_addr,
    input  logic                    miss_dirty,
    input  logic [ADDR_WIDTH-1:0]   victim_addr,
    output logic                    write_back,
    input  logic [LINE_WIDTH-1:0]   cacheline_old,
    output logic                    refresh,
    output logic [LINE_WIDTH-1:0]   cacheline_new,
    output logic                    miss_done,
    output logic                    bus_err,
    output logic                    awvalid,
    input  logic                    awready,
    output logic [ADDR_WIDTH-1:0]   awaddr,
    output logic [3:0]              awid,
    output logic [7:0]              awlen,
    output logic [2:0]              awsize,
    output logic [1:0]              awburst,
    output logic                    wvalid,
    input  logic                    wready,
    output logic [LINE_WIDTH-1:0]   wdata,
    output logic [LINE_WIDTH/8-1:0] wstrb,
    output logic                    wlast,
    input  logic                    bvalid,
    output logic                    bready,
    input  logic [1:0]              bresp,
    output logic                    arvalid,
    input  logic                    arready,
    output logic [ADDR_WIDTH-1:0]   araddr,
    output logic [3:0]              arid,
    output logic [7:0]              arlen,
    output logic [2:0]              arsize,
    output logic [1:0]              arburst,
    input  logic                    rvalid,
    output logic                    rready,
    input  logic [LINE_WIDTH-1:0]   rdata,
    input  logic [1:0]              rresp,
    input  logic                    rlast
);

    localparam int                    OFFSET_BITS = $clog2(LINE_WIDTH / 8);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK  = {ADDR_WIDTH{1'b1}} << OFFSET_BITS;

    state_e                  state, state_next;
    logic [ADDR_WIDTH-1:0]   miss_addr_r;
    logic [ADDR_WIDTH-1:0]   victim_addr_r;
    logic [LINE_WIDTH-1:0]   wdata_r;
    logic                    aw_done, w_done;
    logic                    aw_hs, w_hs;

    // Single-beat transfers: rlast carries no information here.
    logic unused_rlast;
    assign unused_rlast = rlast;

    assign awaddr  = victim_addr_r;
    assign araddr  = miss_addr_r;
    assign wdata   = wdata_r;
    assign awid    = AXI_ID;
    assign arid    = AXI_ID;
    assign awlen   = 8'd0;
    assign arlen   = 8'd0;
    assign awsize  = SIZE_8B;
    assign arsize  = SIZE_8B;
    assign awburst = BURST_INCR;
    assign arburst = BURST_INCR;
    assign wstrb   = '1;
    assign wlast   = 1'b1;

    assign aw_hs = awvalid && awready;
    assign w_hs  = wvalid && wready;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and per-state strobes/valids.
    always_comb begin
        state_next = state;
        write_back = 1'b0;
        refresh    = 1'b0;
        miss_done  = 1'b0;
        awvalid    = 1'b0;
        wvalid     = 1'b0;
        bready     = 1'b0;
        arvalid    = 1'b0;
        rready     = 1'b0;
        case (state)
            S_IDLE: begin
                if (miss_req) begin
                    state_next = miss_dirty ? S_WB_RD : S_RD_AR;
                end
            end
            S_WB_RD: begin
                write_back = 1'b1;
                state_next = S_WB_CAP;
            end
            S_WB_CAP: begin
                state_next = S_WB_AW_W;
            end
            S_WB_AW_W: begin
                awvalid = !aw_done;
                wvalid  = !w_done;
                if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                    state_next = S_WB_B;
                end
            end
            S_WB_B: begin
                bready = 1'b1;
                if (bvalid) begin
                    state_next = S_RD_AR;
                end
            end
            S_RD_AR: begin
                arvalid = 1'b1;
                if (arready) begin
                    state_next = S_RD_R;
                end
            end
            S_RD_R: begin
                rready = 1'b1;
                if (rvalid) begin
                    state_next = S_REFILL;
                end
            end
            S_REFILL: begin
                refresh    = 1'b1;
                state_next = S_DONE;
            end
            S_DONE: begin
                miss_done  = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Address/data capture, AW/W retirement flags and sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            miss_addr_r   <= '0;
            victim_addr_r <= '0;
            wdata_r       <= '0;
            cacheline_new <= '0;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            bus_err       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (miss_req) begin
                        miss_addr_r   <= miss_addr & ALIGN_MASK;
                        victim_addr_r <= victim_addr & ALIGN_MASK;
                    end
                end
                S_WB_CAP: begin
                    wdata_r <= cacheline_old;
                    aw_done <= 1'b0;
                    w_done  <= 1'b0;
                end
                S_WB_AW_W: begin
                    if (aw_hs) aw_done <= 1'b1;
                    if (w_hs)  w_done  <= 1'b1;
                end
                S_WB_B: begin
                    if (bvalid && bresp != RESP_OKAY) bus_err <= 1'b1;
                end
                S_RD_R: begin
                    if (rvalid) begin
                        cacheline_new <= rdata;
                        if (rresp != RESP_OKAY) bus_err <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_refill_ctrl.sv
// Scoreboard bench for dcache_refill_ctrl with a delay-programmable AXI slave.
module tb_dcache_refill_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        miss_req;
    logic [63:0] miss_addr;
    logic        miss_dirty;
    logic [63:0] victim_addr;
    logic        write_back;
    logic [63:0] cacheline_old;
    logic        refresh;
    logic [63:0] cacheline_new;
    logic        miss_done;
    logic        bus_err;
    logic        awvalid, awready;
    logic [63:0] awaddr;
    logic [3:0]  awid;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        wvalid, wready;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        wlast;
    logic        bvalid, bready;
    logic [1:0]  bresp;
    logic        arvalid, arready;
    logic [63:0] araddr;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        rvalid, rready;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;

    dcache_refill_ctrl dut (
        .clk(clk), .rst(rst),
        .miss_req(miss_req), .miss_addr(miss_addr), .miss_dirty(miss_dirty),
        .victim_addr(victim_addr), .write_back(write_back), .cacheline_old(cacheline_old),
        .refresh(refresh), .cacheline_new(cacheline_new), .miss_done(miss_done), .bus_err(bus_err),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid), .awlen(awlen),
        .awsize(awsize), .awburst(awburst),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid), .arlen(arlen),
        .arsize(arsize), .arburst(arburst),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // slave knobs
    int          aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
    logic [1:0]  bresp_val = 2'b00, rresp_val = 2'b00;
    logic [63:0] victim_data = '0, rdata_val = '0;

    // scoreboard
    logic [63:0] exp_aw_addr[$], exp_wdata[$], exp_araddr[$], exp_line[$];
    int          exp_done_cyc[$];
    logic        exp_bus_err = 1'b0;
    int          aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, wb_cnt = 0, refresh_cnt = 0, done_cnt = 0;
    int          tot_aw = 0, tot_wb = 0;

    // Slave model and monitor: observe outputs, then drive inputs, all at negedge.
    initial begin
        int   aw_wait = 0, w_wait = 0, b_wait = 0, ar_wait = 0, r_wait = 0;
        logic prev_wb = 1'b0, aw_hs_prev = 1'b0, w_hs_prev = 1'b0;
        logic aw_open = 1'b0, w_open = 1'b0;
        logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
        logic [63:0] t;
        awready = 0; wready = 0; bvalid = 0; bresp = 0; arready = 0;
        rvalid = 0; rdata = 0; rresp = 0; rlast = 0; cacheline_old = '0;
        forever begin
            @(negedge clk);
            cacheline_old = prev_wb ? victim_data : 64'hBAD0_BAD0_BAD0_BAD0;
            prev_wb = write_back;

            if (aw_hs_prev) check_eq("awvalid_drop", {63'd0, awvalid}, 64'd0);
            if (w_hs_prev)  check_eq("wvalid_drop", {63'd0, wvalid}, 64'd0);
            if (aw_open && !aw_hs_prev) check_eq("awvalid_hold", {63'd0, awvalid}, 64'd1);
            if (w_open && !w_hs_prev)   check_eq("wvalid_hold", {63'd0, wvalid}, 64'd1);

            awready = awvalid && (aw_wait >= aw_delay);
            aw_wait = awvalid ? aw_wait + 1 : 0;
            wready  = wvalid && (w_wait >= w_delay);
            w_wait  = wvalid ? w_wait + 1 : 0;
            bvalid  = bready && (b_wait >= b_delay);
            b_wait  = bready ? b_wait + 1 : 0;
            bresp   = bvalid ? bresp_val : 2'b00;
            arready = arvalid && (ar_wait >= ar_delay);
            ar_wait = arvalid ? ar_wait + 1 : 0;
            rvalid  = rready && (r_wait >= r_delay);
            r_wait  = rready ? r_wait + 1 : 0;
            rdata   = rvalid ? rdata_val : 64'd0;
            rresp   = rvalid ? rresp_val : 2'b00;
            rlast   = rvalid;

            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            b_hs  = bvalid && bready;
            ar_hs = arvalid && arready;
            r_hs  = rvalid && rready;

            if (aw_hs) begin
                aw_cnt++;
                if (exp_aw_addr.size() == 0) check_eq("aw_unexpected", 64'd1, 64'd0);
                else begin
                    t = exp_aw_addr.pop_front();
                    check_eq("awaddr", awaddr, t);
                end
                check_eq("aw_fields", {44'd0, awid, awlen, awsize, awburst}, {44'd0, 4'd1, 8'd0, 3'b011, 2'b01});
            end
            if (w_hs) begin
                w_cnt++;
                if (exp_wdata.size() == 0) check_eq("w_unexpected", 64'd1, 64'd0);
                else begin
                    t = exp_wdata.pop_front();
                    check_eq("wdata", wdata, t);
                end
                check_eq("w_fields", {55'd0, wstrb, wlast}, {55'd0, 8'hFF, 1'b1});
            end
            if (b_hs) begin
                b_cnt++;
                if (bresp_val != 2'b00) exp_bus_err = 1'b1;
            end
            if (ar_hs) begin
                ar_cnt++;
                check_eq("ar_after_b", 64'(b_cnt), 64'(aw_cnt));
                if (exp_araddr.size() == 0) check_eq("ar_unexpected", 64'd1, 64'd0);
                else begin
                    t = exp_araddr.pop_front();
                    check_eq("araddr", araddr, t);
                end
                check_eq("ar_fields", {44'd0, arid, arlen, arsize, arburst}, {44'd0, 4'd1, 8'd0, 3'b011, 2'b01});
            end
            if (r_hs && rresp_val != 2'b00) exp_bus_err = 1'b1;
            if (write_back) wb_cnt++;
            if (refresh) begin
                refresh_cnt++;
                if (exp_line.size() == 0) check_eq("refresh_unexpected", 64'd1, 64'd0);
                else begin
                    t = exp_line.pop_front();
                    check_eq("cacheline_new", cacheline_new, t);
                end
            end
            if (miss_done) begin
                done_cnt++;
                if (exp_done_cyc.size() == 0) check_eq("done_unexpected", 64'd1, 64'd0);
                else check_eq("done_cycle", 64'(cyc), 64'(exp_done_cyc.pop_front()));
                check_eq("bus_err", {63'd0, bus_err}, {63'd0, exp_bus_err});
            end

            if (aw_hs) aw_open = 1'b0; else if (awvalid) aw_open = 1'b1;
            if (w_hs)  w_open  = 1'b0; else if (wvalid)  w_open  = 1'b1;
            aw_hs_prev = aw_hs;
            w_hs_prev  = w_hs;
        end
    end

    // Queue the expectations of one service; caller manages miss_req release.
    task automatic push_service(input logic [63:0] addr, input logic [63:0] vaddr, input logic dirty,
                                input logic [63:0] vdata, input logic [63:0] line, input int done_at);
        exp_araddr.push_back(addr & ~64'h7);
        exp_line.push_back(line);
        exp_done_cyc.push_back(done_at);
        if (dirty) begin
            exp_aw_addr.push_back(vaddr & ~64'h7);
            exp_wdata.push_back(vdata);
            tot_aw++;
            tot_wb++;
        end
    endtask

    task automatic start_miss(input logic [63:0] addr, input logic [63:0] vaddr, input logic dirty,
                              input logic [63:0] vdata, input logic [63:0] line, input int lat);
        @(negedge clk);
        miss_req = 1'b1; miss_addr = addr; victim_addr = vaddr; miss_dirty = dirty;
        victim_data = vdata; rdata_val = line;
        push_service(addr, vaddr, dirty, vdata, line, cyc + lat);
        @(negedge clk);
        miss_req = 1'b0; miss_addr = 64'hFFFF_FFFF_FFFF_FFFF; victim_addr = 64'hFFFF_FFFF_FFFF_FFFF;
        miss_dirty = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int k = 0;
        while (done_cnt < target && k < 200) begin
            @(negedge clk);
            k++;
        end
        check_eq("done_count", 64'(done_cnt), 64'(target));
        repeat (2) @(negedge clk);
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_strobes"},
                 {55'd0, write_back, refresh, miss_done, awvalid, wvalid, bready, arvalid, rready, bus_err},
                 64'd0);
        check_eq({tag, "_line"}, cacheline_new, 64'd0);
    endtask

    initial begin
        int c;
        int k;
        rst = 1'b1; miss_req = 1'b0; miss_addr = '0; miss_dirty = 1'b0; victim_addr = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("reset");

        // clean miss, all ready
        start_miss(64'h8000_1238, 64'h0, 1'b0, 64'h0, 64'hDEAD_BEEF_0123_4567, 4);
        wait_done(1);

        // dirty miss, all ready
        start_miss(64'h8000_2000, 64'h8000_0040, 1'b1, 64'h1111_2222_3333_4444,
                   64'hCAFE_F00D_5555_6666, 8);
        wait_done(2);

        // dirty miss, skewed handshakes, unaligned addresses
        aw_delay = 5; w_delay = 2;
        start_miss(64'h8000_30FF, 64'h8000_0087, 1'b1, 64'hA5A5_5A5A_0F0F_F0F0,
                   64'h0123_4567_89AB_CDEF, 13);
        wait_done(3);
        aw_delay = 0; w_delay = 0;

        // error on write response, delayed B and R
        bresp_val = 2'b10; b_delay = 2; r_delay = 1;
        start_miss(64'h8000_4010, 64'h8000_5010, 1'b1, 64'h7777_8888_9999_AAAA,
                   64'h1357_9BDF_2468_ACE0, 11);
        wait_done(4);
        bresp_val = 2'b00; b_delay = 0; r_delay = 0;
        start_miss(64'h8000_6000, 64'h0, 1'b0, 64'h0, 64'h0F1E_2D3C_4B5A_6978, 4);
        wait_done(5);

        // reset while waiting for R
        r_delay = 1000;
        start_miss(64'h8000_7000, 64'h0, 1'b0, 64'h0, 64'hFFFF_0000_FFFF_0000, 4);
        k = 0;
        while (!rready && k < 50) begin
            @(negedge clk);
            k++;
        end
        check_eq("reached_rd_r", {63'd0, rready}, 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_line.delete(); exp_done_cyc.delete(); exp_bus_err = 1'b0; r_delay = 0;
        check_idle_outputs("mid_reset");
        @(negedge clk);
        check_idle_outputs("post_reset");
        start_miss(64'h8000_8008, 64'h8000_9008, 1'b1, 64'h2222_4444_6666_8888,
                   64'h9999_AAAA_BBBB_CCCC, 8);
        wait_done(6);

        // miss_req held through DONE: two back-to-back services
        @(negedge clk);
        c = cyc;
        miss_req = 1'b1; miss_addr = 64'h8000_A000; miss_dirty = 1'b0; victim_addr = '0;
        rdata_val = 64'h5A5A_5A5A_A5A5_A5A5;
        push_service(64'h8000_A000, 64'h0, 1'b0, 64'h0, 64'h5A5A_5A5A_A5A5_A5A5, c + 4);
        push_service(64'h8000_A000, 64'h0, 1'b0, 64'h0, 64'h5A5A_5A5A_A5A5_A5A5, c + 9);
        repeat (6) @(negedge clk);
        miss_req = 1'b0;
        wait_done(8);
        repeat (10) @(negedge clk);

        check_eq("total_done", 64'(done_cnt), 64'd8);
        check_eq("total_aw", 64'(aw_cnt), 64'(tot_aw));
        check_eq("total_w", 64'(w_cnt), 64'(tot_aw));
        check_eq("total_b", 64'(b_cnt), 64'(tot_aw));
        check_eq("total_wb", 64'(wb_cnt), 64'(tot_wb));
        check_eq("total_ar", 64'(ar_cnt), 64'd9);
        check_eq("total_refresh", 64'(refresh_cnt), 64'd8);
        check_eq("queues_empty",
                 64'(exp_aw_addr.size() + exp_wdata.size() + exp_araddr.size() + exp_line.size() + exp_done_cyc.size()),
                 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule
